uart_mem_bridge: RTL
====================

Name: uart_mem_bridge

Overview:
Host-side debug bridge between the UART byte streams and the memories' debug access port. It parses command frames from the UART receiver and issues single-cycle read or write requests to data memory (type 0) or instruction memory (type 1). It captures the 42-bit read response and serializes it, or a write acknowledge, back to the UART transmitter.

Parameters:
RESP_TIMEOUT, 64, cycles WAIT_RESP waits for a ready pulse before the error reply
FRAME_TIMEOUT, 100000, idle cycles allowed between bytes of one frame before the partial frame is discarded
ACK_BYTE, 8'hA5, reply byte for a completed write
ERR_BYTE, 8'hEE, reply byte for a response timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rx_byte  in  8  received UART byte
rx_valid  in  1  one-cycle strobe qualifying rx_byte
tx_byte  out  8  byte to the UART transmitter
tx_valid  out  1  tx_byte valid; held until accepted
tx_ready  in  1  transmitter accepts tx_byte when tx_valid && tx_ready
cpu_enable  in  1  CPU running; a request may only be issued while this is low
write_mem_req  out  1  one-cycle request strobe
target_mem_type  out  1  0 = data memory, 1 = instruction memory
target_addr  out  9  word address
uart_rx_data_in  out  32  write data
rw_flag  out  1  1 = write, 0 = read
data_mem_tx_data  in  42  data-memory response {1'b0, addr[8:0], data[31:0]}
data_mem_tx_ready  in  1  data-memory response valid
instr_mem_tx_data  in  42  instruction-memory response, same format
instr_mem_tx_ready  in  1  instruction-memory response valid
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, async: state=IDLE; all outputs 0; internal counters 0.
- Frame format:
  - byte0 = {rw, type, 5'b0, addr[8]}
  - byte1 = addr[7:0]
  - write frames only: 4 data bytes, MSB first
- States: IDLE, GET_ADDR, GET_DATA, ISSUE, WAIT_RESP, SEND.
- IDLE: on rx_valid, latch rw, type and addr[8] -> GET_ADDR.
- GET_ADDR: on rx_valid, latch addr[7:0]. rw=1 -> GET_DATA with byte count 0; rw=0 -> ISSUE.
- GET_DATA: shift one byte in per rx_valid. The 4th byte -> ISSUE.
- Frame timeout: in GET_ADDR or GET_DATA, an inter-byte counter reaching FRAME_TIMEOUT -> IDLE, no reply. The counter clears on each rx_valid.
- ISSUE: waits while cpu_enable=1. When cpu_enable=0:
  - write_mem_req=1 for exactly one cycle; target_mem_type, target_addr, uart_rx_data_in and rw_flag are valid in that cycle.
  - target_addr, uart_rx_data_in and rw_flag are registered and remain stable until the next issue; target_mem_type is the selector described below.
- Write: ack is loaded directly after the strobe cycle. SEND with 1 byte = ACK_BYTE.
- Read -> WAIT_RESP:
  - The selected ready is sampled; the expected earliest ready is the cycle after the strobe.
  - On ready, capture the 42-bit word into a 48-bit shift register as {6'b0, resp}. SEND 6 bytes, MSB first: byte0 = {6'b0, resp[41:40]}, then resp[39:32] … resp[7:0].
  - The timeout counter reaching RESP_TIMEOUT -> SEND with 1 byte = ERR_BYTE.
- Ready selection: only the ready matching the latched type is honoured; the other is ignored.
- SEND:
  - tx_valid=1 with tx_byte stable until the handshake.
  - Shift on handshake; after the last byte, tx_valid=0 -> IDLE.
  - Back-to-back: tx_valid may stay high across consecutive bytes.
- rx_valid outside IDLE/GET_ADDR/GET_DATA (ISSUE, WAIT_RESP, SEND): byte is dropped. No queueing.
- Reset mid-frame or mid-send: frame discarded; a partially sent reply is abandoned.

Optional Feature:
UART_BRIDGE_CHECKSUM_EN:
- Defined: every command frame carries a trailing byte equal to the XOR of all preceding frame bytes, checked in an extra GET_CSUM state before ISSUE.
  - Mismatch: no request issued; SEND 1 byte 8'hE1.
  - Every reply gets a trailing XOR byte of its own bytes. Ack reply = A5 A5; read reply = 7 bytes.
- Undefined: no checksum byte either direction; GET_CSUM logic absent.

Test Plan:
- Write frame 80 05 DE AD BE EF, cpu_enable=0 -> one-cycle write_mem_req with type=0, addr=0x005, data=0xDEADBEEF, rw_flag=1; then tx A5.
- Read frame 41 10, with instr_mem_tx_ready pulsed 1 cycle after the strobe carrying {1'b0, 9'h110, 32'h12345678} -> tx 01 10 12 34 56 78.
- Write frame sent with cpu_enable=1 for 20 cycles -> no strobe until cpu_enable falls; strobe occurs exactly once.
- Read frame 00 03 with no ready pulse, RESP_TIMEOUT=64 -> tx EE 64 cycles after the strobe; busy falls after the handshake.
- Byte 80 then silence for FRAME_TIMEOUT -> return to IDLE, no tx. Subsequent read frame 00 01 is processed normally.
- tx_ready held low 10 cycles during a read reply -> tx_byte/tx_valid stable throughout; no byte skipped; full 6-byte sequence is delivered.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// UART command-frame bridge to the data/instruction memory debug port.
// Optional UART_BRIDGE_CHECKSUM_EN adds an XOR checksum byte to frames and replies.
module uart_mem_bridge #(
  parameter int unsigned RESP_TIMEOUT  = 64,
  parameter int unsigned FRAME_TIMEOUT = 100000,
  parameter logic [7:0]  ACK_BYTE      = 8'hA5,
  parameter logic [7:0]  ERR_BYTE      = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        cpu_enable,
  output logic        write_mem_req,
  output logic        target_mem_type,
  output logic [8:0]  target_addr,
  output logic [31:0] uart_rx_data_in,
  output logic        rw_flag,
  input  logic [41:0] data_mem_tx_data,
  input  logic        data_mem_tx_ready,
  input  logic [41:0] instr_mem_tx_data,
  input  logic        instr_mem_tx_ready,
  output logic        busy
);

`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam logic [2:0] CS = 3'd1;
`else
  localparam logic [2:0] CS = 3'd0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_BRIDGE_CHECKSUM_EN
    GET_CSUM,
`endif
    ISSUE,
    WAIT_RESP,
    SEND
  } state_t;

`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam state_t FRAME_END = GET_CSUM;
`else
  localparam state_t FRAME_END = ISSUE;
`endif

  state_t      state, state_n;
  logic        lat_rw, lat_type;
  logic [8:0]  lat_addr;
  logic [31:0] lat_data;
  logic [1:0]  dcnt;
  logic [31:0] cnt;
  logic [47:0] sh;
  logic [2:0]  nleft;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0]  rx_xor, tx_xor;
`endif

  logic        sel_ready;
  logic [41:0] sel_data;
  logic        frame_to, resp_to, hs, resp_ok;

  assign sel_ready       = lat_type ? instr_mem_tx_ready : data_mem_tx_ready;
  assign sel_data        = lat_type ? instr_mem_tx_data  : data_mem_tx_data;
  assign frame_to        = !rx_valid && (cnt == 32'(FRAME_TIMEOUT - 1));
  assign resp_to         = (cnt == 32'(RESP_TIMEOUT - 1));
  assign hs              = tx_valid && tx_ready;
  // The strobe cycle is the first WAIT_RESP cycle; a response is only honoured after it.
  assign resp_ok         = sel_ready && !write_mem_req;
  assign tx_byte         = sh[47:40];
  assign target_mem_type = lat_type;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (rx_valid) state_n = GET_ADDR;
      GET_ADDR: begin
        if (rx_valid)      state_n = lat_rw ? GET_DATA : FRAME_END;
        else if (frame_to) state_n = IDLE;
      end
      GET_DATA: begin
        if (rx_valid && dcnt == 2'd3) state_n = FRAME_END;
        else if (frame_to)            state_n = IDLE;
      end
`ifdef UART_BRIDGE_CHECKSUM_EN
      GET_CSUM: begin
        if (rx_valid)      state_n = (rx_byte == rx_xor) ? ISSUE : SEND;
        else if (frame_to) state_n = IDLE;
      end
`endif
      ISSUE:     if (!cpu_enable) state_n = WAIT_RESP;
      WAIT_RESP: if (lat_rw || resp_ok || resp_to) state_n = SEND;
      SEND:      if (hs && nleft == 3'd1) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_mem_req   <= 1'b0;
      target_addr     <= '0;
      uart_rx_data_in <= '0;
      rw_flag         <= 1'b0;
      tx_valid        <= 1'b0;
      lat_rw          <= 1'b0;
      lat_type        <= 1'b0;
      lat_addr        <= '0;
      lat_data        <= '0;
      dcnt            <= '0;
      cnt             <= '0;
      sh              <= '0;
      nleft           <= '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
      rx_xor          <= '0;
      tx_xor          <= '0;
`endif
    end else begin
      write_mem_req <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_valid) begin
            lat_rw      <= rx_byte[7];
            lat_type    <= rx_byte[6];
            lat_addr[8] <= rx_byte[0];
`ifdef UART_BRIDGE_CHECKSUM_EN
            rx_xor      <= rx_byte;
`endif
          end
        end
        GET_ADDR, GET_DATA
`ifdef UART_BRIDGE_CHECKSUM_EN
        , GET_CSUM
`endif
        : begin
          cnt <= rx_valid ? '0 : cnt + 32'd1;
          if (rx_valid) begin
`ifdef UART_BRIDGE_CHECKSUM_EN
            rx_xor <= rx_xor ^ rx_byte;
`endif
            if (state == GET_ADDR) begin
              lat_addr[7:0] <= rx_byte;
              dcnt          <= '0;
            end else if (state == GET_DATA) begin
              lat_data <= {lat_data[23:0], rx_byte};
              dcnt     <= dcnt + 2'd1;
            end
`ifdef UART_BRIDGE_CHECKSUM_EN
            else if (rx_byte != rx_xor) begin
              sh       <= {8'hE1, 40'h0};
              nleft    <= 3'd1 + CS;
              tx_valid <= 1'b1;
              tx_xor   <= '0;
            end
`endif
          end
        end
        ISSUE: begin
          if (!cpu_enable) begin
            write_mem_req   <= 1'b1;
            target_addr     <= lat_addr;
            uart_rx_data_in <= lat_rw ? lat_data : '0;
            rw_flag         <= lat_rw;
            cnt             <= '0;
          end
        end
        WAIT_RESP: begin
          if (lat_rw || (!resp_ok && resp_to)) begin
            sh       <= {(lat_rw ? ACK_BYTE : ERR_BYTE), 40'h0};
            nleft    <= 3'd1 + CS;
            tx_valid <= 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
            tx_xor   <= '0;
`endif
          end else if (resp_ok) begin
            sh       <= {6'b0, sel_data};
            nleft    <= 3'd6 + CS;
            tx_valid <= 1'b1;
`ifdef UART_BRIDGE_CHECKSUM_EN
            tx_xor   <= '0;
`endif
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SEND: begin
          if (hs) begin
            if (nleft == 3'd1) begin
              tx_valid <= 1'b0;
            end else begin
`ifdef UART_BRIDGE_CHECKSUM_EN
              // Running XOR of sent bytes becomes the final byte of the reply.
              tx_xor <= tx_xor ^ sh[47:40];
              if (nleft == 3'd2) sh <= {tx_xor ^ sh[47:40], 40'h0};
              else               sh <= {sh[39:0], 8'h00};
`else
              sh <= {sh[39:0], 8'h00};
`endif
              nleft <= nleft - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
